// File: rtl/di_bus_arbiter.sv
// di_bus_arbiter
//   Shares one device-interface (di) register bus between two masters
//   (master 0 = HostInterface di port, master 1 = on-chip sequencer).
//   Round-robin, one transaction at a time: latch the winner's request,
//   hold the bus address, wait for rdwr_ready, issue one single-cycle
//   diRead/diWrite strobe, return read data with a one-cycle ack.
//
//   Parameters:
//     READ_LAT  cycles from diRead strobe to diRegDataOut valid (1..7)
//     TIMEOUT   max WAIT_RDY cycles before abort (1..65535)
//   Build option:
//     DI_ARB_TIMEOUT_EN  when defined, WAIT_RDY aborts after TIMEOUT cycles
//                        and flags m*_err; otherwise it waits indefinitely
//                        and m*_err is tied low.
//
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     m*_ep/addr/wdata/rd/wr        master requests (level, sampled in IDLE)
//     m*_ack/rdata/err              per-master completion pulse, data, error
//     diEpAddr/diRegAddr/diRegDataIn/diRead/diWrite   bus to the slaves
//     diRegDataOut, rdwr_ready      slave read data and ready
//     grant, busy                   one-hot owner, transaction in progress
module di_bus_arbiter #(
   parameter int READ_LAT = 1,
   parameter int TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] m0_ep,
   input  logic [15:0] m0_addr,
   input  logic [15:0] m0_wdata,
   input  logic        m0_rd,
   input  logic        m0_wr,
   output logic        m0_ack,
   output logic [15:0] m0_rdata,
   output logic        m0_err,
   input  logic [15:0] m1_ep,
   input  logic [15:0] m1_addr,
   input  logic [15:0] m1_wdata,
   input  logic        m1_rd,
   input  logic        m1_wr,
   output logic        m1_ack,
   output logic [15:0] m1_rdata,
   output logic        m1_err,
   output logic [15:0] diEpAddr,
   output logic [15:0] diRegAddr,
   output logic [15:0] diRegDataIn,
   output logic        diRead,
   output logic        diWrite,
   input  logic [15:0] diRegDataOut,
   input  logic        rdwr_ready,
   output logic [1:0]  grant,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WAIT_RDY = 3'd1,
      ST_STROBE   = 3'd2,
      ST_CAPTURE  = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t      state_r;
   state_t      next_s;
   logic        last_r;      // master that owns / last owned the bus
   logic        op_wr_r;
   logic [2:0]  lat_cnt_r;
   logic        req0_s;
   logic        req1_s;
   logic        sel_m1_s;
   logic        sel_wr_s;
   logic        cap_last_s;
   logic        timeout_s;
   logic        start_s;

   logic [15:0] ep_r;
   logic [15:0] addr_r;
   logic [15:0] wdata_r;
   logic        rd_stb_r;
   logic        wr_stb_r;
   logic        m0_ack_r;
   logic        m1_ack_r;
   logic [15:0] m0_rdata_r;
   logic [15:0] m1_rdata_r;
   logic [1:0]  grant_r;
   logic        busy_r;

   // Elaboration-time range check of the configuration.
   if (READ_LAT < 1 || READ_LAT > 7 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
      $error("di_bus_arbiter: READ_LAT or TIMEOUT out of range");
   end

   assign req0_s     = m0_rd | m0_wr;
   assign req1_s     = m1_rd | m1_wr;
   // On a tie the master that did not own the bus last wins.
   assign sel_m1_s   = req1_s & (~req0_s | ~last_r);
   // rd and wr both high counts as a write.
   assign sel_wr_s   = sel_m1_s ? m1_wr : m0_wr;
   assign cap_last_s = (lat_cnt_r == 3'(READ_LAT - 1));
   assign start_s    = (state_r == ST_IDLE) && (next_s == ST_WAIT_RDY);

`ifdef DI_ARB_TIMEOUT_EN
   logic [15:0] to_cnt_r;
   logic        m0_err_r;
   logic        m1_err_r;

   assign timeout_s = (state_r == ST_WAIT_RDY) && !rdwr_ready &&
                      (to_cnt_r == 16'(TIMEOUT - 1));

   // WAIT_RDY cycle counter and per-master error flags (pulse with ack).
   always_ff @(posedge clk) begin
      if (reset) begin
         to_cnt_r <= 16'd0;
         m0_err_r <= 1'b0;
         m1_err_r <= 1'b0;
      end else begin
         to_cnt_r <= (state_r == ST_WAIT_RDY) ? (to_cnt_r + 16'd1) : 16'd0;
         m0_err_r <= timeout_s & ~last_r;
         m1_err_r <= timeout_s & last_r;
      end
   end

   assign m0_err = m0_err_r;
   assign m1_err = m1_err_r;
`else
   assign timeout_s = 1'b0;
   assign m0_err    = 1'b0;
   assign m1_err    = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req0_s || req1_s) begin
               next_s = ST_WAIT_RDY;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_WAIT_RDY: begin
            if (rdwr_ready) begin
               next_s = ST_STROBE;
            end else if (timeout_s) begin
               next_s = ST_DONE;
            end else begin
               next_s = ST_WAIT_RDY;
            end
         end
         ST_STROBE: begin
            if (op_wr_r) begin
               next_s = ST_DONE;
            end else begin
               next_s = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            if (cap_last_s) begin
               next_s = ST_DONE;
            end else begin
               next_s = ST_CAPTURE;
            end
         end
         ST_DONE: next_s = ST_IDLE;
         default: next_s = ST_IDLE;
      endcase
   end

   // Transaction latch, registered bus strobes, grant/busy/ack and read data.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_r     <= 1'b1;
         op_wr_r    <= 1'b0;
         lat_cnt_r  <= 3'd0;
         ep_r       <= 16'd0;
         addr_r     <= 16'd0;
         wdata_r    <= 16'd0;
         rd_stb_r   <= 1'b0;
         wr_stb_r   <= 1'b0;
         m0_ack_r   <= 1'b0;
         m1_ack_r   <= 1'b0;
         m0_rdata_r <= 16'd0;
         m1_rdata_r <= 16'd0;
         grant_r    <= 2'b00;
         busy_r     <= 1'b0;
      end else begin
         if (start_s) begin
            last_r  <= sel_m1_s;
            op_wr_r <= sel_wr_s;
            grant_r <= sel_m1_s ? 2'b10 : 2'b01;
            ep_r    <= sel_m1_s ? m1_ep    : m0_ep;
            addr_r  <= sel_m1_s ? m1_addr  : m0_addr;
            wdata_r <= sel_m1_s ? m1_wdata : m0_wdata;
         end else if (next_s == ST_DONE) begin
            grant_r <= 2'b00;
         end
         // Strobes are registered from the decision to enter STROBE,
         // which is only reachable from WAIT_RDY with rdwr_ready=1.
         rd_stb_r  <= (next_s == ST_STROBE) & ~op_wr_r;
         wr_stb_r  <= (next_s == ST_STROBE) & op_wr_r;
         busy_r    <= (next_s != ST_IDLE);
         m0_ack_r  <= (next_s == ST_DONE) & ~last_r;
         m1_ack_r  <= (next_s == ST_DONE) & last_r;
         lat_cnt_r <= (state_r == ST_CAPTURE) ? (lat_cnt_r + 3'd1) : 3'd0;
         if ((state_r == ST_CAPTURE) && cap_last_s) begin
            if (last_r) begin
               m1_rdata_r <= diRegDataOut;
            end else begin
               m0_rdata_r <= diRegDataOut;
            end
         end else if (timeout_s) begin
            if (last_r) begin
               m1_rdata_r <= 16'h0000;
            end else begin
               m0_rdata_r <= 16'h0000;
            end
         end
      end
   end

   assign diEpAddr    = ep_r;
   assign diRegAddr   = addr_r;
   assign diRegDataIn = wdata_r;
   assign diRead      = rd_stb_r;
   assign diWrite     = wr_stb_r;
   assign m0_ack      = m0_ack_r;
   assign m1_ack      = m1_ack_r;
   assign m0_rdata    = m0_rdata_r;
   assign m1_rdata    = m1_rdata_r;
   assign grant       = grant_r;
   assign busy        = busy_r;

endmodule

// File: tb/tb_di_bus_arbiter.sv
// Testbench for di_bus_arbiter: directed transactions, scoreboard queue of
// expected acks checked by an independent monitor on the falling edge.
module tb_di_bus_arbiter;

   localparam int READ_LAT = 1;
   localparam int TIMEOUT  = 4;
`ifdef DI_ARB_TIMEOUT_EN
   localparam int RDY_LOW  = 3;
`else
   localparam int RDY_LOW  = 6;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] m0_ep, m0_addr, m0_wdata, m1_ep, m1_addr, m1_wdata;
   logic        m0_rd, m0_wr, m1_rd, m1_wr;
   logic        m0_ack, m1_ack, m0_err, m1_err;
   logic [15:0] m0_rdata, m1_rdata;
   logic [15:0] diEpAddr, diRegAddr, diRegDataIn, diRegDataOut;
   logic        diRead, diWrite, rdwr_ready, busy;
   logic [1:0]  grant;

   di_bus_arbiter #(.READ_LAT(READ_LAT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .m0_ep(m0_ep), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rd(m0_rd), .m0_wr(m0_wr), .m0_ack(m0_ack),
      .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_ep(m1_ep), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_ack(m1_ack),
      .m1_rdata(m1_rdata), .m1_err(m1_err),
      .diEpAddr(diEpAddr), .diRegAddr(diRegAddr), .diRegDataIn(diRegDataIn),
      .diRead(diRead), .diWrite(diWrite), .diRegDataOut(diRegDataOut),
      .rdwr_ready(rdwr_ready), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Slave: read data is valid the cycle after diRead, value = addr + 0x1000.
   always @(posedge clk) diRegDataOut <= diRead ? (diRegAddr + 16'h1000) : 16'hDEAD;

   typedef struct {
      int          mst;
      logic        wr;
      logic [15:0] ep;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      logic        err;
      int          ack_cyc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] rd_model [2];
   int          checks = 0;
   int          errors = 0;
   int          strobes = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Monitor: checks every strobe and every ack against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (diRead || diWrite) begin
         strobes++;
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected actual=%0d%0d required=no strobe (cycle %0d)", diRead, diWrite, cyc);
         end else begin
            e = sb[0];
            chk("strobe_type", 32'({diRead, diWrite}), e.wr ? 32'h1 : 32'h2);
            chk("bus_ep", 32'(diEpAddr), 32'(e.ep));
            chk("bus_addr", 32'(diRegAddr), 32'(e.addr));
            chk("bus_wdata", 32'(diRegDataIn), 32'(e.wdata));
         end
      end
      if (m0_ack || m1_ack) begin
         chk("ack_exclusive", 32'(m0_ack & m1_ack), 32'h0);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected actual=%0d%0d required=no ack (cycle %0d)", m1_ack, m0_ack, cyc);
         end else begin
            e = sb.pop_front();
            chk("ack_master", m1_ack ? 32'h1 : 32'h0, 32'(e.mst));
            chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
            chk("ack_rdata", 32'(m1_ack ? m1_rdata : m0_rdata), 32'(e.rdata));
            chk("ack_err", 32'(m1_ack ? m1_err : m0_err), 32'(e.err));
            chk("strobe_count", 32'(strobes), e.err ? 32'h0 : 32'h1);
         end
         strobes = 0;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int mst, input logic rd, input logic wr,
                        input logic [15:0] ep, input logic [15:0] addr, input logic [15:0] wdata);
      if (mst == 1) begin
         m1_rd = rd; m1_wr = wr; m1_ep = ep; m1_addr = addr; m1_wdata = wdata;
      end else begin
         m0_rd = rd; m0_wr = wr; m0_ep = ep; m0_addr = addr; m0_wdata = wdata;
      end
   endtask

   task automatic push(input int mst, input logic wr, input logic [15:0] ep,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic err, input int ack_cyc);
      exp_t e;
      if (err) rd_model[mst] = 16'h0000;
      else if (!wr) rd_model[mst] = addr + 16'h1000;
      e.mst = mst; e.wr = wr; e.ep = ep; e.addr = addr; e.wdata = wdata;
      e.rdata = rd_model[mst]; e.err = err; e.ack_cyc = ack_cyc;
      sb.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; rdwr_ready = 1'b1;
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      rd_model[0] = 16'h0; rd_model[1] = 16'h0;
      tick(3);
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_bus", 32'(diEpAddr | diRegAddr | diRegDataIn), 32'h0);
      chk("rst_strobes_acks", 32'({diRead, diWrite, m0_ack, m1_ack, m0_err, m1_err}), 32'h0);
      chk("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'h0);
      reset = 1'b0;
      tick(1);

      // Single write by m0 with ready high: ack 3 cycles after request.
      n = cyc;
      drive(0, 1'b0, 1'b1, 16'h0001, 16'h0004, 16'hA5A5);
      push(0, 1'b1, 16'h0001, 16'h0004, 16'hA5A5, 1'b0, n + 3);
      tick(1);
      chk("wr_grant_c1", 32'(grant), 32'h1);
      chk("wr_busy_c1", 32'(busy), 32'h1);
      drive(0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      tick(1);
      chk("wr_strobe_c2", 32'(diWrite), 32'h1);
      chk("wr_grant_c2", 32'(grant), 32'h1);
      tick(1);
      chk("wr_grant_c3", 32'(grant), 32'h0);
      tick(2);
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_bus_hold", 32'({diEpAddr, diRegAddr}), 32'h00010004);

      // Single read by m1: data 0x1234, ack 4 cycles after request.
      n = cyc;
      drive(1, 1'b1, 1'b0, 16'h0002, 16'h0234, 16'h0BAD);
      push(1, 1'b0, 16'h0002, 16'h0234, 16'h0BAD, 1'b0, n + 4);
      tick(1);
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick(5);
      chk("m0_rdata_hold", 32'(m0_rdata), 32'h0);
      chk("m1_rdata_hold", 32'(m1_rdata), 32'h1234);

      // Both masters hold read requests: m0, m1, m0, m1.
      n = cyc;
      drive(0, 1'b1, 1'b0, 16'h0003, 16'h0010, 16'h0000);
      drive(1, 1'b1, 1'b0, 16'h0004, 16'h0020, 16'h0000);
      push(0, 1'b0, 16'h0003, 16'h0010, 16'h0000, 1'b0, n + 4);
      push(1, 1'b0, 16'h0004, 16'h0020, 16'h0000, 1'b0, n + 9);
      push(0, 1'b0, 16'h0003, 16'h0010, 16'h0000, 1'b0, n + 14);
      push(1, 1'b0, 16'h0004, 16'h0020, 16'h0000, 1'b0, n + 19);
      tick(16);
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick(5);

      // Ready held low after grant; strobe one cycle after ready rises.
      rdwr_ready = 1'b0;
      n = cyc;
      drive(0, 1'b0, 1'b1, 16'h0005, 16'h0006, 16'h0007);
      push(0, 1'b1, 16'h0005, 16'h0006, 16'h0007, 1'b0, n + RDY_LOW + 3);
      tick(1);
      drive(0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF);
      for (int i = 1; i <= RDY_LOW; i++) begin
         chk("wait_no_strobe", 32'(diWrite), 32'h0);
         chk("wait_addr_stable", 32'({diEpAddr, diRegAddr}), 32'h00050006);
         tick(1);
      end
      rdwr_ready = 1'b1;
      chk("ready_cycle_no_strobe", 32'(diWrite), 32'h0);
      tick(1);
      chk("ready_strobe", 32'(diWrite), 32'h1);
      tick(3);

`ifdef DI_ARB_TIMEOUT_EN
      // Ready stuck low: abort after TIMEOUT WAIT_RDY cycles with err.
      rdwr_ready = 1'b0;
      n = cyc;
      drive(0, 1'b1, 1'b0, 16'h0008, 16'h0040, 16'h0000);
      push(0, 1'b0, 16'h0008, 16'h0040, 16'h0000, 1'b1, n + TIMEOUT + 1);
      tick(1);
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick(7);
      rdwr_ready = 1'b1;
      n = cyc;
      drive(0, 1'b0, 1'b1, 16'h0008, 16'h0041, 16'h5555);
      push(0, 1'b1, 16'h0008, 16'h0041, 16'h5555, 1'b0, n + 3);
      tick(1);
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick(4);
`endif

      // Reset while in WAIT_RDY: clean abort, pointer back to last=1.
      rdwr_ready = 1'b0;
      drive(0, 1'b0, 1'b1, 16'h0009, 16'h0009, 16'h0009);
      tick(2);
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick(1);
      chk("rst_mid_busy", 32'(busy), 32'h0);
      chk("rst_mid_grant", 32'(grant), 32'h0);
      chk("rst_mid_bus", 32'(diEpAddr), 32'h0);
      reset = 1'b0; rdwr_ready = 1'b1;
      rd_model[0] = 16'h0; rd_model[1] = 16'h0;
      tick(1);
      n = cyc;
      drive(0, 1'b0, 1'b1, 16'h000A, 16'h00A0, 16'h1111);
      drive(1, 1'b0, 1'b1, 16'h000B, 16'h00B0, 16'h2222);
      push(0, 1'b1, 16'h000A, 16'h00A0, 16'h1111, 1'b0, n + 3);
      push(1, 1'b1, 16'h000B, 16'h00B0, 16'h2222, 1'b0, n + 7);
      tick(5);
      drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      tick(6);

      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
